dual_issue_queue: RTL
=====================

Name: dual_issue_queue

Overview:
- Parametrised instruction buffer between fetch and the two decode/issue slots (p0_IR_in / p1_IR_in) of the dual-issue CPU.
- Accepts up to two 16-bit instructions per cycle into a DEPTH-entry circular queue.
- Each cycle it presents the oldest instruction on slot 0 and the next one on slot 1 when the pair is hazard-free.
- Replaces directly driven IR registers; adds flush, back-pressure, a single-issue mode and a pairing statistic.

Parameters:
- DEPTH, 8, queue entries; power of two, at least 4.
- IW, 16, instruction width; the field positions below assume 16.
- PAIR_EN, 1, 1 = dual-issue allowed; 0 = slot 1 never valid.
- CNT_W, 16, width of pair_count.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  discard all queued entries; used on branch redirect.
- in_valid  in  2  bit0 = in_instr0 valid, bit1 = in_instr1 valid; bit1 is only legal with bit0 set.
- in_instr0  in  IW  older fetched instruction.
- in_instr1  in  IW  younger fetched instruction.
- in_ready  out  1  at least 2 free entries.
- p0_IR  out  IW  slot 0 instruction; 16'h0000 when not valid.
- p0_valid  out  1  slot 0 holds an instruction.
- p1_IR  out  IW  slot 1 instruction; 16'h0000 when not valid.
- p1_valid  out  1  slot 1 holds a pairable instruction.
- issue_ready  in  1  pipeline accepts the presented slot(s) this cycle.
- count  out  log2(DEPTH)+1  current occupancy.
- pair_count  out  CNT_W  number of dual issues since reset.

Behaviour:
- Reset (synchronous, active-high): head = tail = count = 0 and pair_count = 0. Outputs are then p0_valid = p1_valid = 0, p0_IR = p1_IR = 0 and in_ready = 1.
- Storage is registered. p0/p1 outputs are combinational from the head entries (0-cycle read latency).
- An instruction pushed at edge N is visible on p0 at edge N+1 at the earliest.

Decode fields for hazard checks (op = [15:13]):
- Destination:
  - MOV imm (110, [12:11] = 10) writes Rn = [10:8].
  - MOV reg (110, 00) writes Rd = [7:5].
  - ALU (101), except CMP ([12:11] = 01), writes Rd.
  - LDR (011) writes Rd.
  - Nothing else writes a register.
- Sources:
  - MOV reg reads Rm = [2:0].
  - ALU reads Rn and Rm.
  - LDR reads Rn.
  - STR (100) reads Rn and Rd.
- Memory ops: 011 and 100.
- Control ops: 001, 010 and 111 (branch/call/halt).

Slot rules:
- p0_valid = (count >= 1).
- p1_valid = PAIR_EN and count >= 2, and none of the following hold:
  - p1 reads p0's destination (RAW);
  - both write the same register (WAW);
  - both are memory ops;
  - p0 or p1 is a control op;
  - p0 is CMP and p1 is opcode 001.

Pop, push and occupancy:
- pop = issue_ready ? (p0_valid + p1_valid) : 0.
- head advances by pop. pair_count increments when pop == 2; it saturates at all-ones.
- push = in_ready ? popcount(in_valid) : 0. in_instr0 is written at tail and in_instr1 at tail+1. tail advances by push.
- in_ready is computed from pre-pop occupancy: in_ready = (DEPTH - count >= 2).
- Simultaneous push and pop in one cycle is allowed: count_next = count + push - pop.
- Pointers wrap modulo DEPTH. Full = count == DEPTH; empty = count == 0.
- Pushes presented while in_ready = 0 are ignored; the fetch side must hold them.

Flush and reset priority:
- flush takes priority over push and pop in the same cycle. head = tail = count = 0; pair_count is kept; same-cycle push is dropped.
- Reset mid-operation overrides flush, push and pop.
- Whenever a slot is not valid, its IR output is driven to 16'h0000, which the pipeline treats as a bubble.

Test Plan:
- Reset, then push {D102 (MOV R1,#2), 8224 (STR R1,[R2,#4])}, issue_ready = 1 -> next cycle p0 = D102, p0_valid = 1, p1_valid = 0 (RAW on R1), p1_IR = 0000. The following cycle p0 = 8224, then empty with both slots 0000.
- Push {8224, 6264 (LDR R3)} -> p0 = 8224 alone (both memory). Next cycle p0 = 6264, count = 0 after. pair_count stays 0.
- Push {D705 (MOV R7,#5), A586 (ADD R4,R5,R6)} -> p0 = D705, p1 = A586, both valid. After one cycle count = 0 and pair_count = 1.
- DEPTH = 8, issue_ready = 0, push 2 per cycle for 4 cycles -> count = 8, in_ready low after count = 6 to 8. A fifth push is ignored. Then issue_ready = 1 drains in FIFO order across the wrap boundary.
- count = 5 with flush = 1 and push of {D102, 8280} in the same cycle -> next cycle count = 0, p0_valid = 0, outputs 0000, pair_count unchanged.
- PAIR_EN = 0 with stream D705, A586, E000 -> one instruction per cycle, p1_valid never 1. E000 (halt) issues alone and pair_count = 0.

Source files
------------

// File: rtl/dual_issue_queue.sv
// Instruction buffer between fetch and the two issue slots of the dual-issue core.
// A circular queue that takes up to two instructions per cycle and pairs the head two when they are hazard-free.
module dual_issue_queue #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned IW      = 16,
  parameter bit          PAIR_EN = 1'b1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [1:0]               in_valid,
  input  logic [IW-1:0]            in_instr0,
  input  logic [IW-1:0]            in_instr1,
  output logic                     in_ready,
  output logic [IW-1:0]            p0_IR,
  output logic                     p0_valid,
  output logic [IW-1:0]            p1_IR,
  output logic                     p1_valid,
  input  logic                     issue_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         pair_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [IW-1:0]    mem_q [DEPTH];
  logic [PW-1:0]    head_q, tail_q, head_nx, tail_nx;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] pair_q;
  logic [1:0]       push, pop;
  logic [IW-1:0]    p0_raw, p1_raw;
  logic [3:0]       d0, d1;
  logic             hazard;

  // Returns {writes, reg} for the destination register of an instruction.
  function automatic logic [3:0] dest_of(input logic [IW-1:0] i);
    dest_of = 4'b0000;
    if (i[15:13] == 3'b110 && i[12:11] == 2'b10)      dest_of = {1'b1, i[10:8]};
    else if (i[15:13] == 3'b110 && i[12:11] == 2'b00) dest_of = {1'b1, i[7:5]};
    else if (i[15:13] == 3'b101 && i[12:11] != 2'b01) dest_of = {1'b1, i[7:5]};
    else if (i[15:13] == 3'b011)                      dest_of = {1'b1, i[7:5]};
  endfunction

  function automatic logic reads_reg(input logic [IW-1:0] i, input logic [2:0] r);
    reads_reg = 1'b0;
    case (i[15:13])
      3'b110:  reads_reg = (i[12:11] == 2'b00) && (i[2:0] == r);
      3'b101:  reads_reg = (i[10:8] == r) || (i[2:0] == r);
      3'b011:  reads_reg = (i[10:8] == r);
      3'b100:  reads_reg = (i[10:8] == r) || (i[7:5] == r);
      default: reads_reg = 1'b0;
    endcase
  endfunction

  function automatic logic is_mem(input logic [IW-1:0] i);
    is_mem = (i[15:13] == 3'b011) || (i[15:13] == 3'b100);
  endfunction

  function automatic logic is_ctrl(input logic [IW-1:0] i);
    is_ctrl = (i[15:13] == 3'b001) || (i[15:13] == 3'b010) || (i[15:13] == 3'b111);
  endfunction

  always_comb begin
    p0_raw = mem_q[head_q];
    p1_raw = mem_q[head_q + PW'(1)];
    d0     = dest_of(p0_raw);
    d1     = dest_of(p1_raw);
    hazard = (d0[3] && reads_reg(p1_raw, d0[2:0]))
           || (d0[3] && d1[3] && (d0[2:0] == d1[2:0]))
           || (is_mem(p0_raw) && is_mem(p1_raw))
           || is_ctrl(p0_raw) || is_ctrl(p1_raw)
           || ((p0_raw[15:11] == 5'b10101) && (p1_raw[15:13] == 3'b001));

    p0_valid = (count_q != '0);
    p1_valid = PAIR_EN && (count_q >= CW'(2)) && !hazard;
    p0_IR    = p0_valid ? p0_raw : '0;
    p1_IR    = p1_valid ? p1_raw : '0;

    // Readiness uses pre-pop occupancy so fetch never depends on issue timing.
    in_ready = (count_q <= CW'(DEPTH - 2));
    push     = in_ready ? ({1'b0, in_valid[0]} + {1'b0, in_valid[1]}) : 2'd0;
    pop      = issue_ready ? ({1'b0, p0_valid} + {1'b0, p1_valid}) : 2'd0;

    head_nx  = head_q + PW'(pop);
    tail_nx  = tail_q + PW'(push);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      pair_q  <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_nx;
      tail_q  <= tail_nx;
      count_q <= count_d;
      if (pop == 2'd2 && pair_q != '1) pair_q <= pair_q + CNT_W'(1);
    end
  end

  // Storage needs no reset: slot outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      if (push != 2'd0) mem_q[tail_q] <= in_instr0;
      if (push == 2'd2) mem_q[tail_q + PW'(1)] <= in_instr1;
    end
  end

  assign count      = count_q;
  assign pair_count = pair_q;

endmodule
